// File: rtl/mips_mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared constants and types for the MIPS data memory and its
//            memory-mapped register block.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  // Default RAM depth: 2^8 words
  localparam int unsigned C_DEFAULT_DEPTH_LOG2 = 8;

  // Address bits [31:28] equal to this value select the MMIO region
  localparam logic [3:0] C_MMIO_BASE = 4'hF;

  // Byte offsets of the MMIO registers from 0xF0000000
  localparam logic [3:0] C_OFF_IO_OUT      = 4'h0;
  localparam logic [3:0] C_OFF_CYCLE       = 4'h4;
  localparam logic [3:0] C_OFF_STORE_COUNT = 4'h8;
  localparam logic [3:0] C_OFF_STATUS      = 4'hC;

  // STATUS register bit positions
  localparam int unsigned C_STATUS_MISALIGNED_BIT = 0;

  // Register select, taken from the word part of the MMIO offset
  typedef enum logic [1:0] {
    REG_IO_OUT      = C_OFF_IO_OUT[3:2],
    REG_CYCLE       = C_OFF_CYCLE[3:2],
    REG_STORE_COUNT = C_OFF_STORE_COUNT[3:2],
    REG_STATUS      = C_OFF_STATUS[3:2]
  } mmio_reg_e;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mips_mmio_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_mmio_regs
// Purpose  : IO_OUT, CYCLE, STORE_COUNT and STATUS registers of the data
//            memory MMIO window, with their counters and read mux.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mmio_regs
  import mips_mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,                 // asynchronous, active-low
  input  logic         i_reg_we,            // aligned store to a mapped MMIO offset
  input  mmio_reg_e    i_reg_sel,
  input  logic [N-1:0] i_wdata,
  input  logic         i_ram_store,         // a RAM store commits this edge
  input  logic         i_misaligned_store,  // a store was dropped this edge
  output logic [N-1:0] o_rdata,
  output logic [N-1:0] o_io_out,
  output logic         o_misaligned
);

  logic [N-1:0] r_io_out;
  logic [N-1:0] r_cycle;
  logic [N-1:0] r_store_count;
  logic         r_misaligned;

  logic [N-1:0] w_store_count_nxt;
  logic         w_status_clr;

  assign w_status_clr = i_reg_we && (i_reg_sel == REG_STATUS)
                        && i_wdata[C_STATUS_MISALIGNED_BIT];

  // Saturating store counter; the register is reloaded every edge so its
  // next value always comes from this single expression
  assign w_store_count_nxt = (i_ram_store && (r_store_count != '1))
                             ? r_store_count + N'(1) : r_store_count;

  // Register state; set of the sticky flag wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_io_out      <= '0;
      r_cycle       <= '0;
      r_store_count <= '0;
      r_misaligned  <= 1'b0;
    end else begin
      r_cycle       <= r_cycle + N'(1);
      r_store_count <= w_store_count_nxt;
      if (i_reg_we && (i_reg_sel == REG_IO_OUT)) begin
        r_io_out <= i_wdata;
      end
      if (i_misaligned_store) begin
        r_misaligned <= 1'b1;
      end else if (w_status_clr) begin
        r_misaligned <= 1'b0;
      end
    end
  end

  // Read mux; unused STATUS bits read as zero
  always_comb begin
    o_rdata = '0;
    case (i_reg_sel)
      REG_IO_OUT:      o_rdata = r_io_out;
      REG_CYCLE:       o_rdata = r_cycle;
      REG_STORE_COUNT: o_rdata = r_store_count;
      REG_STATUS:      o_rdata[C_STATUS_MISALIGNED_BIT] = r_misaligned;
      default:         o_rdata = '0;
    endcase
  end

  assign o_io_out     = r_io_out;
  assign o_misaligned = r_misaligned;

endmodule : mips_mmio_regs
`default_nettype wire

// File: rtl/mips_data_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_data_memory
// Purpose  : Single-port word RAM with combinational read, synchronous write
//            and a small MMIO window at 0xF0000000 for a MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
module mips_data_memory
  import mips_mem_pkg::*;
#(
  parameter int N          = 32,
  parameter int DEPTH_LOG2 = C_DEFAULT_DEPTH_LOG2,
  parameter     INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         rst,          // asynchronous, active-low
  input  logic         MemWrite,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] write_data,
  output logic [N-1:0] read_data,
  output logic [N-1:0] io_out,
  output logic         misaligned
);

  localparam int C_WORDS = 2 ** DEPTH_LOG2;

  logic [N-1:0] r_mem [0:C_WORDS-1];

  logic                  w_is_mmio;
  logic                  w_mmio_mapped;
  logic                  w_aligned;
  logic [DEPTH_LOG2-1:0] w_word_idx;
  logic                  w_ram_we;
  logic                  w_mmio_we;
  logic                  w_misaligned_store;
  logic [N-1:0]          w_mmio_rdata;

  // Address decode; upper RAM address bits are ignored so the RAM aliases
  assign w_is_mmio     = (addr[N-1 -: 4] == C_MMIO_BASE);
  assign w_mmio_mapped = (addr[N-5:4] == '0);
  assign w_aligned     = (addr[1:0] == 2'b00);
  assign w_word_idx    = addr[DEPTH_LOG2+1:2];

  // A store arriving while reset is asserted is discarded, not just uncounted
  assign w_ram_we           = MemWrite && w_aligned && !w_is_mmio && rst;
  assign w_mmio_we          = MemWrite && w_aligned && w_is_mmio && w_mmio_mapped;
  assign w_misaligned_store = MemWrite && !w_aligned;

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_word_idx] <= write_data;
    end
  end

  mips_mmio_regs #(
    .N (N)
  ) u_mmio (
    .clk                (clk),
    .rst                (rst),
    .i_reg_we           (w_mmio_we),
    .i_reg_sel          (mmio_reg_e'(addr[3:2])),
    .i_wdata            (write_data),
    .i_ram_store        (w_ram_we),
    .i_misaligned_store (w_misaligned_store),
    .o_rdata            (w_mmio_rdata),
    .o_io_out           (io_out),
    .o_misaligned       (misaligned)
  );

  // Zero-latency read of the addressed word; unmapped MMIO offsets read 0
  always_comb begin
    read_data = r_mem[w_word_idx];
    if (w_is_mmio) begin
      read_data = w_mmio_mapped ? w_mmio_rdata : '0;
    end
  end

endmodule : mips_data_memory
`default_nettype wire

// File: tb/tb_mips_data_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_data_memory
// Purpose  : Directed plus randomized bench for mips_data_memory against a
//            behavioural model of the memory map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_data_memory;

  localparam int DL    = 8;
  localparam int WORDS = 1 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic [31:0] io_out;
  logic        misaligned;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_mem [int];
  logic [31:0] m_io    = 32'h0;
  logic [31:0] m_cycle = 32'h0;
  logic [31:0] m_sc    = 32'h0;
  logic        m_mis   = 1'b0;

  logic [31:0] cmp_e;
  bit          cmp_known;

  always #5 clk = ~clk;

  mips_data_memory #(
    .N          (32),
    .DEPTH_LOG2 (DL),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .io_out     (io_out),
    .misaligned (misaligned)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected load value for an address, from the memory map rules
  function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
    int w;
    known = 1'b1;
    if (a[31:28] == 4'hF) begin
      case (a & 32'hFFFF_FFFC)
        32'hF000_0000: return m_io;
        32'hF000_0004: return m_cycle;
        32'hF000_0008: return m_sc;
        32'hF000_000C: return {31'b0, m_mis};
        default:       return 32'h0;
      endcase
    end
    w = int'((a >> 2) % WORDS);
    if (m_mem.exists(w)) return m_mem[w];
    known = 1'b0;
    return 32'h0;
  endfunction

  // Model update: one committed edge at a time, reset clears everything but RAM
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_io = 32'h0; m_cycle = 32'h0; m_sc = 32'h0; m_mis = 1'b0;
    end else begin
      if (MemWrite) begin
        if (addr[1:0] != 2'b00) begin
          m_mis = 1'b1;
        end else if (addr[31:28] == 4'hF) begin
          if (addr == 32'hF000_0000) m_io = write_data;
          else if (addr == 32'hF000_000C && write_data[0]) m_mis = 1'b0;
        end else begin
          m_mem[int'((addr >> 2) % WORDS)] = write_data;
          if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
        end
      end
      m_cycle = m_cycle + 32'd1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp_e = exp_read(addr, cmp_known);
      if (cmp_known) check("read_data", read_data, cmp_e);
      check("io_out", io_out, m_io);
      check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    end
  end

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite   = we;
    addr       = a;
    write_data = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c1;
    logic [31:0] prev;
    logic [31:0] ra;
    bit          found;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_io_out", io_out, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);
    addr = 32'hF000_0004; #1;
    check("rst_cycle", read_data, 32'h0);
    addr = 32'hF000_0008; #1;
    check("rst_store_count", read_data, 32'h0);
    chk_en = 1'b1;

    // Release and idle: CYCLE counts from the first edge after release
    @(negedge clk);
    rst = 1'b1; MemWrite = 1'b0; addr = 32'hF000_0000;
    repeat (100) @(posedge clk);
    step(1'b0, 32'hF000_0004, 32'h0); #1;
    check("cycle_100", read_data, 32'd100);

    // Store then load
    step(1'b1, 32'h10, 32'hDEAD_BEEF);
    step(1'b0, 32'h10, 32'h0); #1;
    check("load_deadbeef", read_data, 32'hDEAD_BEEF);
    step(1'b0, 32'hF000_0008, 32'h0); #1;
    check("store_count_1", read_data, 32'd1);

    // Same-cycle read and store return the old word
    step(1'b1, 32'h10, 32'h1111_1111); #1;
    check("read_during_write", read_data, 32'hDEAD_BEEF);
    step(1'b0, 32'h10, 32'h0); #1;
    check("after_write", read_data, 32'h1111_1111);
    step(1'b0, 32'h12, 32'h0); #1;
    check("misaligned_read", read_data, 32'h1111_1111);
    check("misaligned_read_flag", {31'b0, misaligned}, 32'h0);

    // Aliasing past the RAM depth
    step(1'b1, 32'h400, 32'h1234_5678);
    step(1'b0, 32'h0, 32'h0); #1;
    check("alias", read_data, 32'h1234_5678);

    // Misaligned store dropped, flag set, W1C clears it
    step(1'b1, 32'h13, 32'hFFFF_FFFF);
    step(1'b0, 32'h10, 32'h0); #1;
    check("misaligned_dropped", read_data, 32'h1111_1111);
    check("misaligned_set", {31'b0, misaligned}, 32'h1);
    step(1'b1, 32'hF000_000C, 32'h1);
    step(1'b0, 32'hF000_000C, 32'h0); #1;
    check("misaligned_cleared", {31'b0, misaligned}, 32'h0);

    // MMIO: IO_OUT, unmapped offset, RO write
    step(1'b1, 32'hF000_0000, 32'h0000_00A5);
    step(1'b0, 32'hF000_0010, 32'h0); #1;
    check("io_out_a5", io_out, 32'h0000_00A5);
    check("unmapped_read", read_data, 32'h0);
    step(1'b0, 32'hF000_0004, 32'h0); #1;
    c1 = read_data;
    step(1'b1, 32'hF000_0004, 32'h0);
    step(1'b0, 32'hF000_0004, 32'h0); #1;
    check("cycle_ro", read_data, c1 + 32'd2);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 7) ra = 32'($urandom_range(0, 511)) << 2;
      else ra = 32'hF000_0000 + (32'($urandom_range(0, 5)) << 2);
      if ($urandom_range(0, 4) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), ra, $urandom);
    end

    // Asynchronous reset in the middle of a store
    step(1'b1, 32'hF000_0000, 32'h5A5A_5A5A);
    step(1'b1, 32'h21, 32'h0);
    step(1'b1, 32'h20, 32'hAAAA_5555);
    step(1'b1, 32'h20, 32'h1212_1212); #1;
    check("pre_rst_io_out", io_out, 32'h5A5A_5A5A);
    check("pre_rst_misaligned", {31'b0, misaligned}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_io_out", io_out, 32'h0);
    check("async_misaligned", {31'b0, misaligned}, 32'h0);
    @(posedge clk);
    step(1'b0, 32'h20, 32'h0); #1;
    check("ram_retained", read_data, 32'hAAAA_5555);
    step(1'b0, 32'hF000_0008, 32'h0); #1;
    check("rst_store_lost", read_data, 32'h0);
    step(1'b0, 32'hF000_0004, 32'h0);
    rst = 1'b1;
    step(1'b0, 32'hF000_0004, 32'h0); #1;
    check("cycle_restart", read_data, 32'd1);

    // Counter boundaries using forced register values
    chk_en = 1'b0;
    step(1'b0, 32'hF000_0008, 32'h0);
    force dut.u_mmio.r_store_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_mmio.r_store_count;
    #1;
    check("sc_forced", read_data, 32'hFFFF_FFFE);
    step(1'b1, 32'h30, 32'h1);
    step(1'b0, 32'hF000_0008, 32'h0); #1;
    check("sc_reach_max", read_data, 32'hFFFF_FFFF);
    step(1'b1, 32'h34, 32'h2);
    step(1'b0, 32'hF000_0008, 32'h0); #1;
    check("sc_saturate", read_data, 32'hFFFF_FFFF);

    step(1'b0, 32'hF000_0004, 32'h0);
    force dut.u_mmio.r_cycle = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.u_mmio.r_cycle;
    prev  = 32'h0;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i > 0 && prev == 32'hFFFF_FFFF && read_data == 32'h0) found = 1'b1;
      prev = read_data;
      @(negedge clk);
    end
    check("cycle_wrap", {31'b0, found}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mips_data_memory
`default_nettype wire
